// File: rtl/cordic_mult_sched.sv
// Round-robin arbiter sharing one start/done multiplier among NUM_REQ requesters with a done watchdog.
// Latency: accept->mul_start 1 cycle, response 1 cycle after done; holds response and stalls all requesters while rsp_ready is low.
module cordic_mult_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_x,
  input  logic [NUM_REQ*8-1:0] req_z,
  output logic                 mul_start,
  output logic [7:0]           mul_x,
  output logic [7:0]           mul_z,
  input  logic                 mul_done,
  input  logic [15:0]          mul_y,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_y,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [7:0]       x_q, x_d;
  logic [7:0]       z_q, z_d;
  logic [15:0]      y_q, y_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_found;
  logic [ID_W-1:0]  sel_idx;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Scan from the highest offset down so the nearest valid requester after ptr wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(ptr_q, k)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    x_d       = x_q;
    z_d       = z_q;
    y_d       = y_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    mul_start = 1'b0;
    case (state_q)
      IDLE: begin
        // Never grant on a reset edge: the requester would believe its op was taken.
        if (sel_found && !rst) begin
          req_ready[sel_idx] = 1'b1;
          x_d     = req_x[{sel_idx, 3'b000} +: 8];
          z_d     = req_z[{sel_idx, 3'b000} +: 8];
          id_d    = sel_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mul_start = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mul_done) begin
          y_d     = mul_y;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          y_d     = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          ptr_d   = wrap_idx(id_q, 1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      x_q     <= '0;
      z_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      x_q     <= x_d;
      z_q     <= z_d;
      y_q     <= y_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mul_x     = x_q;
  assign mul_z     = z_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_y     = y_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cordic_mult_sched.sv
// Randomized scoreboard bench for cordic_mult_sched with a latency-programmable core model.
module tb_cordic_mult_sched;
  localparam int NR = 4, IDW = 2, TO = 64, NEVER = 1000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*8-1:0] req_x = '0, req_z = '0;
  logic            mul_start;
  logic [7:0]      mul_x, mul_z;
  logic            mul_done = 1'b0;
  logic [15:0]     mul_y = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [IDW-1:0]  rsp_id;
  logic [15:0]     rsp_y;
  logic            rsp_err;
  logic            busy;

  cordic_mult_sched #(.NUM_REQ(NR), .ID_W(IDW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_z(req_z), .mul_start(mul_start), .mul_x(mul_x), .mul_z(mul_z),
    .mul_done(mul_done), .mul_y(mul_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] x; logic [7:0] z; int lat; } op_t;
  typedef struct { int id; logic [15:0] y; logic err; int t; } exp_t;

  op_t  opq [NR][$];
  exp_t sbq [$];

  int errors = 0, checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  // Spec rule: first valid requester scanning upward from ptr, wrapping.
  function automatic int rr_pick(input int p, input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  function automatic void push(input int r, input int x, input int z, input int lat);
    op_t o;
    o.x = 8'(x); o.z = 8'(z); o.lat = lat;
    opq[r].push_back(o);
  endfunction

  // Requester / response-ready drivers
  bit  has_op [NR];
  int  cur_lat [NR];
  int  acc_cnt [NR];
  int  seen [NR];
  bit  wd_en = 1'b0;
  int  rdy_mode = 0;
  op_t dop;

  initial begin
    for (int i = 0; i < NR; i++) begin has_op[i] = 0; seen[i] = 0; cur_lat[i] = 0; end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (acc_cnt[i] != seen[i]) begin seen[i] = acc_cnt[i]; has_op[i] = 0; end
        if (!has_op[i] && opq[i].size() > 0) begin
          dop = opq[i].pop_front();
          req_x[i*8 +: 8] = dop.x;
          req_z[i*8 +: 8] = dop.z;
          cur_lat[i] = dop.lat;
          has_op[i] = 1;
        end
        req_valid[i] = has_op[i] && !(wd_en && $urandom_range(5) == 0);
      end
      rsp_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
    end
  end

  // Core model: done exactly lat cycles after start, junk on mul_y otherwise
  int          done_cyc = -1;
  logic [15:0] core_prod = '0;
  initial begin
    forever begin
      @(posedge clk); #1;
      mul_done = (cyc == done_cyc);
      mul_y    = mul_done ? core_prod : 16'($urandom);
    end
  end

  // Monitor / scoreboard
  int            m_ptr = 0;
  bit            m_busy = 0;
  int            start_exp = -1;
  logic [7:0]    infl_x = '0, infl_z = '0;
  int            infl_lat = 0;
  bit            in_rsp = 0;
  int            first_cyc = 0;
  logic [18:0]   prev_rsp = '0;
  logic [NR-1:0] exp_rdy, acc;
  int            g, ai;
  exp_t          e;

  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      m_busy = 0; m_ptr = 0; start_exp = -1; in_rsp = 0;
    end else begin
      chk(busy === m_busy, "busy", 32'(busy), 32'(m_busy));
      exp_rdy = '0;
      if (!m_busy) begin
        g = rr_pick(m_ptr, req_valid);
        if (g >= 0) exp_rdy[g] = 1'b1;
      end
      chk(req_ready === exp_rdy, "req_ready", 32'(req_ready), 32'(exp_rdy));

      if (mul_start || cyc == start_exp) begin
        chk(mul_start === 1'b1 && cyc == start_exp, "mul_start", 32'(mul_start), 32'(cyc == start_exp));
        chk({mul_x, mul_z} === {infl_x, infl_z}, "mul_operands", {16'h0, mul_x, mul_z}, {16'h0, infl_x, infl_z});
        if (mul_start) begin
          done_cyc  = cyc + infl_lat;
          core_prod = prod(infl_x, infl_z);
        end
        start_exp = -1;
      end

      if (rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1; first_cyc = cyc; prev_rsp = {rsp_id, rsp_y, rsp_err};
        end else begin
          chk({rsp_id, rsp_y, rsp_err} === prev_rsp, "rsp_hold", 32'({rsp_id, rsp_y, rsp_err}), 32'(prev_rsp));
        end
        if (rsp_ready) begin
          in_rsp = 0; m_busy = 0;
          if (sbq.size() == 0) begin
            chk(1'b0, "rsp_unexpected", 32'(rsp_id), 32'(0));
          end else begin
            e = sbq.pop_front();
            chk(int'(rsp_id) == e.id, "rsp_id", 32'(rsp_id), 32'(e.id));
            chk(rsp_y === e.y, "rsp_y", 32'(rsp_y), 32'(e.y));
            chk(rsp_err === e.err, "rsp_err", 32'(rsp_err), 32'(e.err));
            chk(first_cyc == e.t, "rsp_latency", 32'(first_cyc), 32'(e.t));
          end
        end
      end

      acc = req_valid & req_ready;
      if (acc != 0) begin
        ai = 0;
        for (int i = 0; i < NR; i++) if (acc[i]) ai = i;
        infl_x   = req_x[ai*8 +: 8];
        infl_z   = req_z[ai*8 +: 8];
        infl_lat = cur_lat[ai];
        e.id  = ai;
        e.err = (infl_lat > TO);
        e.y   = e.err ? 16'h0 : prod(infl_x, infl_z);
        e.t   = cyc + (e.err ? TO + 2 : infl_lat + 2);
        sbq.push_back(e);
        m_busy = 1; m_ptr = (ai + 1) % NR; start_exp = cyc + 1;
        acc_cnt[ai]++;
      end
    end
  end

  task automatic check_reset_vals();
    chk(req_ready === '0, "rst_req_ready", 32'(req_ready), 0);
    chk(mul_start === 1'b0, "rst_mul_start", 32'(mul_start), 0);
    chk(mul_x === 8'h0, "rst_mul_x", 32'(mul_x), 0);
    chk(mul_z === 8'h0, "rst_mul_z", 32'(mul_z), 0);
    chk(rsp_valid === 1'b0, "rst_rsp_valid", 32'(rsp_valid), 0);
    chk(rsp_id === '0, "rst_rsp_id", 32'(rsp_id), 0);
    chk(rsp_y === 16'h0, "rst_rsp_y", 32'(rsp_y), 0);
    chk(rsp_err === 1'b0, "rst_rsp_err", 32'(rsp_err), 0);
    chk(busy === 1'b0, "rst_busy", 32'(busy), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals();
  endtask

  task automatic wait_idle(input int lim);
    bit done, pend;
    done = 0;
    for (int n = 0; n < lim && !done; n++) begin
      @(negedge clk);
      pend = 0;
      for (int i = 0; i < NR; i++) if (opq[i].size() != 0 || has_op[i]) pend = 1;
      if (!pend && !m_busy && sbq.size() == 0) done = 1;
    end
    chk(done, "drain_timeout", 32'(sbq.size()), 0);
  endtask

  initial begin
    bit got, saw;
    int sel, lat;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals();

    // single op: -128*127 = 0xC080
    push(2, -128, 127, 10);
    wait_idle(200);

    // all four continuously valid from reset
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      push(0, 3, 5, 4); push(1, -7, 9, 7); push(2, 127, 127, 2); push(3, -1, -1, 9);
    end
    wait_idle(400);

    // backpressure: response held 20 cycles with other requests waiting
    rdy_mode = 2;
    push(1, 33, -44, 3); push(3, -90, 21, 3);
    got = 0;
    for (int n = 0; n < 100 && !got; n++) begin @(negedge clk); got = rsp_valid; end
    chk(got, "bp_rsp_seen", 32'(got), 1);
    repeat (20) @(negedge clk);
    rdy_mode = 0;
    wait_idle(300);

    // timeout, then normal service; done/timeout coincidence; one past it
    push(3, 11, -12, NEVER);
    wait_idle(200);
    push(0, -5, 6, 5);
    wait_idle(100);
    push(1, 100, -100, TO);
    push(2, 7, 7, TO + 1);
    wait_idle(400);

    // randomized traffic
    wd_en = 1; rdy_mode = 1;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(9);
      lat = (sel == 0) ? TO : (sel == 1) ? TO + 1 : (sel == 2) ? NEVER : 1 + $urandom_range(11);
      push($urandom_range(NR - 1), $urandom_range(255), $urandom_range(255), lat);
    end
    wait_idle(8000);
    wd_en = 0; rdy_mode = 0;
    push(2, 1, 1, 2);
    wait_idle(100);

    // reset mid-WAIT with a stray done afterwards
    push(1, 50, 60, 20);
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin @(negedge clk); got = mul_start; end
    chk(got, "mid_start_seen", 32'(got), 1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals();
    saw = 0;
    repeat (25) begin @(negedge clk); if (rsp_valid || busy) saw = 1; end
    chk(!saw, "stray_done_ignored", 32'(saw), 0);
    push(0, 2, 3, 3); push(1, 4, 5, 3); push(2, 6, 7, 3); push(3, 8, 9, 3);
    @(negedge clk);
    chk(req_ready === 4'b0001, "first_grant_after_reset", 32'(req_ready), 1);
    wait_idle(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cordic_mult_sched.md
# cordic_mult_sched

Round-robin scheduler that shares one iterative approximate CORDIC multiplier core (8-bit signed x, z in; 16-bit product out; start/done handshake) among NUM_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The scheduler issues one operation at a time to the core, waits for its done pulse under a watchdog, and returns the tagged result on a single valid/ready response channel. It sits between the accelerator front-end ports and the multiplier instance.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- ID_W, 2: requester tag width, equal to clog2(NUM_REQ)
- TIMEOUT, 64: maximum cycles to wait for mul_done after mul_start
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_x  in  NUM_REQ*8  packed signed multiplicands; requester i in bits [8i+7:8i]
- req_z  in  NUM_REQ*8  packed signed multipliers, same packing
- mul_start  out  1  one-cycle start pulse to core
- mul_x, mul_z  out  8 each  operands to core, stable from mul_start until the op ends
- mul_done  in  1  core completion pulse; mul_y valid in the same cycle
- mul_y  in  16  core product, two's complement
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  requester index of the response
- rsp_y  out  16  product (0 on timeout)
- rsp_err  out  1  1 = watchdog timeout, no product
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, select the first requester whose req_valid is set, scanning from ptr upward with wrap modulo NUM_REQ.
  - Assert req_ready for the selected requester only, combinationally in that cycle.
  - Latch its x, z and index. Go to ISSUE.
- ISSUE: mul_start=1 for exactly one cycle. Clear the watchdog counter. Go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - If mul_done: capture mul_y, set err=0, go to RESP.
  - Else if counter == TIMEOUT-1: set y=0, err=1, go to RESP.
  - If mul_done and timeout occur in the same cycle, mul_done wins and err=0.
- RESP:
  - rsp_valid=1. rsp_id, rsp_y and rsp_err are held stable until rsp_ready.
  - On the rsp_valid && rsp_ready cycle: ptr <= served index + 1 (mod NUM_REQ), then go to IDLE.
- mul_done outside WAIT is ignored.
- req_valid deasserted by a requester before it is selected: no state change and no error.
- Operands are passed to the core unmodified. The scheduler does no arithmetic on results; sign and width are as delivered by the core.

## Timing
- Reset values: state=IDLE, ptr=0, req_ready=0, mul_start=0, mul_x=mul_z=0, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_err=0, busy=0.
- Reset asserted in any state returns the block to IDLE on the next edge.
  - An in-flight core op is abandoned.
  - A later stray mul_done is ignored.
- Request accepted in cycle 0 → mul_start in cycle 1 → WAIT from cycle 2.
- mul_done sampled in cycle t → rsp_valid high in cycle t+1.
- rsp_valid && rsp_ready in cycle r → IDLE in r+1; the next accept can happen in r+1.
- With core latency L (mul_done L cycles after mul_start) and rsp_ready held high, steady-state throughput is one op per L+3 cycles.
- Timeout: mul_start in cycle 1, no done → rsp_valid with err in cycle 1+TIMEOUT+1.
- Fairness: with all requesters continuously valid, each is served once per NUM_REQ ops. After reset the first grant goes to requester 0.
- req_ready is never high in ISSUE, WAIT or RESP.

## Test plan
- Single op: requester 2 with x=-128, z=127; core model L=10, exact product → rsp_id=2, rsp_y=0xC080 (-16256), rsp_err=0, rsp_valid in cycle 12 after accept.
- All four requesters valid from reset with distinct operands (e.g. 3×5, -7×9, 127×127, -1×-1) → grant order 0,1,2,3,0… and each rsp_y matches that requester's operands.
- Backpressure: rsp_ready held low for 20 cycles in RESP → rsp_valid, rsp_id, rsp_y stable throughout, req_ready stays 0, no second mul_start.
- Timeout: core never asserts done, TIMEOUT=64 → rsp_err=1, rsp_y=0, rsp_valid 65 cycles after mul_start; the next request is then served normally.
- Coincidence: mul_done asserted in the exact cycle the counter reaches TIMEOUT-1 → rsp_err=0 and the captured product is returned.
- Reset mid-WAIT: rst pulsed 5 cycles after mul_start, then core done arrives → all outputs at reset values, no rsp_valid, ptr=0.
